// File: rtl/mem_ctrl_pkg.sv
// Shared types and defaults for the MEM-stage data memory access controller.
// Imported by the controller, its timeout counter and the dmem interface users.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int unsigned ACK_TIMEOUT_DEF = 15;
  localparam int unsigned CNT_W           = 4;

  function automatic logic is_aligned(input logic [1:0] lsb);
    return (lsb == 2'b00);
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Data memory request/ack bus between the MEM stage and the data memory.
// The controller drives the request side; the memory answers with ack/rdata.
interface mem_access_ctrl_if;

  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req,
    output dmem_we,
    output dmem_addr,
    output dmem_wdata,
    input  dmem_ack,
    input  dmem_rdata
  );

  modport slave (
    input  dmem_req,
    input  dmem_we,
    input  dmem_addr,
    input  dmem_wdata,
    output dmem_ack,
    output dmem_rdata
  );

endinterface

// File: rtl/mem_timeout_cnt.sv
// 4-bit BUSY-cycle counter with synchronous clear, enable and terminal flag.
// The terminal flag marks the last BUSY cycle allowed before an abort.
module mem_timeout_cnt
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned TERM = ACK_TIMEOUT_DEF - 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_term
);

  localparam logic [CNT_W-1:0] TERM_V = CNT_W'(TERM);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_term = (r_cnt == TERM_V);

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data memory access controller: issues one dmem access per
// EX/MEM instruction, stalls the pipe until ack or timeout, reports errors.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        MEM_InALUResult,
  input  logic [31:0]        MEM_InRtData,
  input  logic               MEM_InMemRead,
  input  logic               MEM_InMemWrite,
  mem_access_ctrl_if.master  dmem,
  output logic [31:0]        MEM_OutReadData,
  output logic               MEM_Stall,
  output logic               MEM_AlignErr,
  output logic               MEM_TimeoutErr
);

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_rdata;
  logic        r_align_err;
  logic        r_tmo_err;

  logic w_req;
  logic w_aligned;
  logic w_load;
  logic w_busy;
  logic w_stall;
  logic w_clr;
  logic w_en;
  logic w_term;
  logic w_align_d;
  logic w_tmo_d;
  logic w_cap;
  logic w_zero;

  assign w_req     = MEM_InMemRead | MEM_InMemWrite;
  assign w_aligned = is_aligned(MEM_InALUResult[1:0]);
  // A combined read+write is treated as a store: no load result update.
  assign w_load    = MEM_InMemRead & ~MEM_InMemWrite;

  mem_timeout_cnt #(
    .TERM (ACK_TIMEOUT - 1)
  ) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_clr),
    .i_en   (w_en),
    .o_term (w_term)
  );

  always_comb begin
    w_next    = r_state;
    w_busy    = 1'b0;
    w_stall   = 1'b0;
    w_clr     = 1'b0;
    w_en      = 1'b0;
    w_align_d = 1'b0;
    w_tmo_d   = 1'b0;
    w_cap     = 1'b0;
    w_zero    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_req && w_aligned) begin
          w_stall = 1'b1;
          w_clr   = 1'b1;
          w_next  = S_BUSY;
        end else if (w_req) begin
          w_align_d = 1'b1;
        end
      end
      S_BUSY: begin
        w_busy  = 1'b1;
        w_stall = 1'b1;
        unique case (1'b1)
          dmem.dmem_ack: begin
            w_cap  = w_load;
            w_next = S_DONE;
          end
          w_term: begin
            w_tmo_d = 1'b1;
            w_zero  = w_load;
            w_next  = S_DONE;
          end
          default: w_en = 1'b1;
        endcase
      end
      // One dead cycle so the still-held request is not issued twice.
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_rdata     <= '0;
      r_align_err <= 1'b0;
      r_tmo_err   <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_align_err <= w_align_d;
      r_tmo_err   <= w_tmo_d;
      if (w_cap) begin
        r_rdata <= dmem.dmem_rdata;
      end else if (w_zero) begin
        r_rdata <= '0;
      end
    end
  end

  assign dmem.dmem_req   = w_busy;
  assign dmem.dmem_we    = w_busy & MEM_InMemWrite;
  assign dmem.dmem_addr  = MEM_InALUResult;
  assign dmem.dmem_wdata = MEM_InRtData;

  assign MEM_OutReadData = r_rdata;
  assign MEM_Stall       = w_stall;
  assign MEM_AlignErr    = r_align_err;
  assign MEM_TimeoutErr  = r_tmo_err;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl.
// Each task drives one scenario and compares against hand-computed values.
module tb_mem_access_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        rd;
  logic        wr;
  logic [31:0] rdata_o;
  logic        stall;
  logic        aerr;
  logic        terr;

  int passed;
  int total;

  mem_access_ctrl_if dmem_if ();

  mem_access_ctrl #(
    .ACK_TIMEOUT (15)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .MEM_InALUResult (addr),
    .MEM_InRtData    (wdata),
    .MEM_InMemRead   (rd),
    .MEM_InMemWrite  (wr),
    .dmem            (dmem_if.master),
    .MEM_OutReadData (rdata_o),
    .MEM_Stall       (stall),
    .MEM_AlignErr    (aerr),
    .MEM_TimeoutErr  (terr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp)
      $display("FAIL %s: got %h want %h", name, got, exp);
    else
      passed++;
  endtask

  task automatic run_access(
    input  logic        r,
    input  logic        w,
    input  logic [31:0] a,
    input  logic [31:0] d,
    input  int          ack_at,
    input  logic [31:0] rd_val,
    output int          stalls,
    output int          busy_n,
    output logic        we_s,
    output logic [31:0] addr_s,
    output logic [31:0] wdata_s,
    output logic [31:0] rdata_done,
    output logic        terr0,
    output logic        aerr0,
    output logic        terr1,
    output logic        aerr1,
    output bit          hung
  );
    stalls  = 0;
    busy_n  = 0;
    we_s    = 1'b0;
    addr_s  = '0;
    wdata_s = '0;
    hung    = 1'b1;
    @(negedge clk);
    rd = r; wr = w; addr = a; wdata = d;
    dmem_if.dmem_ack = 1'b0;
    for (int c = 0; c < 40; c++) begin
      #1;
      dmem_if.dmem_ack = 1'b0;
      if (dmem_if.dmem_req) begin
        busy_n++;
        we_s    = dmem_if.dmem_we;
        addr_s  = dmem_if.dmem_addr;
        wdata_s = dmem_if.dmem_wdata;
        if (busy_n == ack_at) begin
          dmem_if.dmem_ack   = 1'b1;
          dmem_if.dmem_rdata = rd_val;
        end
      end
      if (stall) begin
        stalls++;
      end else begin
        hung = 1'b0;
        break;
      end
      @(negedge clk);
    end
    rdata_done = rdata_o;
    terr0 = terr;
    aerr0 = aerr;
    @(negedge clk);
    rd = 1'b0; wr = 1'b0;
    dmem_if.dmem_ack = 1'b0;
    #1;
    terr1 = terr;
    aerr1 = aerr;
  endtask

  int          st, bn;
  logic        we_s, t0, a0, t1, a1;
  logic [31:0] ad_s, wd_s, rdd;
  bit          hung;

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_rdata", rdata_o, 32'h0);
    chk("reset_req", {31'b0, dmem_if.dmem_req}, 32'h0);
    chk("reset_stall", {31'b0, stall}, 32'h0);
    chk("reset_errs", {30'b0, aerr, terr}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_load();
    run_access(1, 0, 32'h100, 32'h0, 1, 32'hDEADBEEF,
               st, bn, we_s, ad_s, wd_s, rdd, t0, a0, t1, a1, hung);
    chk("load_hung", {31'b0, hung}, 32'h0);
    chk("load_stalls", st, 32'd2);
    chk("load_busy", bn, 32'd1);
    chk("load_addr", ad_s, 32'h100);
    chk("load_we", {31'b0, we_s}, 32'h0);
    chk("load_rdata", rdd, 32'hDEADBEEF);
    chk("load_errs", {28'b0, t0, a0, t1, a1}, 32'h0);
  endtask

  task automatic test_store();
    run_access(0, 1, 32'h204, 32'h12345678, 4, 32'h55555555,
               st, bn, we_s, ad_s, wd_s, rdd, t0, a0, t1, a1, hung);
    chk("store_hung", {31'b0, hung}, 32'h0);
    chk("store_stalls", st, 32'd5);
    chk("store_busy", bn, 32'd4);
    chk("store_we", {31'b0, we_s}, 32'h1);
    chk("store_addr", ad_s, 32'h204);
    chk("store_wdata", wd_s, 32'h12345678);
    chk("store_rdata", rdd, 32'hDEADBEEF);
  endtask

  task automatic test_read_write();
    run_access(1, 1, 32'h300, 32'hA5A5A5A5, 2, 32'hAAAA5555,
               st, bn, we_s, ad_s, wd_s, rdd, t0, a0, t1, a1, hung);
    chk("rw_stalls", st, 32'd3);
    chk("rw_we", {31'b0, we_s}, 32'h1);
    chk("rw_wdata", wd_s, 32'hA5A5A5A5);
    chk("rw_rdata", rdd, 32'hDEADBEEF);
  endtask

  task automatic test_ack_outside();
    @(negedge clk);
    dmem_if.dmem_ack   = 1'b1;
    dmem_if.dmem_rdata = 32'h11111111;
    @(negedge clk);
    dmem_if.dmem_ack = 1'b0;
    #1;
    chk("stray_ack_rdata", rdata_o, 32'hDEADBEEF);
    chk("stray_ack_req", {31'b0, dmem_if.dmem_req}, 32'h0);
  endtask

  task automatic test_misalign();
    run_access(1, 0, 32'h102, 32'h0, 1, 32'h22222222,
               st, bn, we_s, ad_s, wd_s, rdd, t0, a0, t1, a1, hung);
    chk("align_stalls", st, 32'd0);
    chk("align_busy", bn, 32'd0);
    chk("align_err_before", {31'b0, a0}, 32'h0);
    chk("align_err_pulse", {31'b0, a1}, 32'h1);
    @(negedge clk);
    #1;
    chk("align_err_cleared", {31'b0, aerr}, 32'h0);
    chk("align_rdata", rdata_o, 32'hDEADBEEF);
  endtask

  task automatic test_reset_mid_busy();
    @(negedge clk);
    rd = 1'b1; addr = 32'h80;
    repeat (2) @(negedge clk);
    #1;
    chk("rstbusy_req_before", {31'b0, dmem_if.dmem_req}, 32'h1);
    rst = 1'b0;
    #1;
    chk("rstbusy_req_drop", {31'b0, dmem_if.dmem_req}, 32'h0);
    chk("rstbusy_rdata", rdata_o, 32'h0);
    rd = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    run_access(1, 0, 32'h84, 32'h0, 2, 32'hCAFEF00D,
               st, bn, we_s, ad_s, wd_s, rdd, t0, a0, t1, a1, hung);
    chk("rstbusy_next_stalls", st, 32'd3);
    chk("rstbusy_next_rdata", rdd, 32'hCAFEF00D);
  endtask

  task automatic test_timeout();
    run_access(1, 0, 32'h40, 32'h0, 0, 32'h0,
               st, bn, we_s, ad_s, wd_s, rdd, t0, a0, t1, a1, hung);
    chk("tmo_hung", {31'b0, hung}, 32'h0);
    chk("tmo_busy", bn, 32'd15);
    chk("tmo_stalls", st, 32'd16);
    chk("tmo_pulse", {31'b0, t0}, 32'h1);
    chk("tmo_rdata", rdd, 32'h0);
    chk("tmo_pulse_end", {31'b0, t1}, 32'h0);
    chk("tmo_idle_req", {31'b0, dmem_if.dmem_req}, 32'h0);
  endtask

  task automatic test_back_to_back();
    int eps;
    eps = 0;
    @(negedge clk);
    rd = 1'b1; addr = 32'h10;
    #1;
    chk("b2b_c0_stall", {31'b0, stall}, 32'h1);
    @(negedge clk);
    #1;
    if (dmem_if.dmem_req) eps++;
    dmem_if.dmem_ack = 1'b1; dmem_if.dmem_rdata = 32'h0000AAAA;
    @(negedge clk);
    dmem_if.dmem_ack = 1'b0;
    addr = 32'h14;
    #1;
    chk("b2b_done_req", {30'b0, dmem_if.dmem_req, stall}, 32'h0);
    chk("b2b_first_rdata", rdata_o, 32'h0000AAAA);
    @(negedge clk);
    #1;
    chk("b2b_idle_stall", {30'b0, stall, dmem_if.dmem_req}, 32'h2);
    @(negedge clk);
    #1;
    if (dmem_if.dmem_req) eps++;
    chk("b2b_second_addr", dmem_if.dmem_addr, 32'h14);
    dmem_if.dmem_ack = 1'b1; dmem_if.dmem_rdata = 32'h0000BBBB;
    @(negedge clk);
    dmem_if.dmem_ack = 1'b0;
    rd = 1'b0;
    #1;
    chk("b2b_second_rdata", rdata_o, 32'h0000BBBB);
    chk("b2b_episodes", eps, 32'd2);
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst    = 1'b0;
    rd     = 1'b0;
    wr     = 1'b0;
    addr   = '0;
    wdata  = '0;
    dmem_if.dmem_ack   = 1'b0;
    dmem_if.dmem_rdata = '0;
    test_reset();
    test_load();
    test_store();
    test_read_write();
    test_ack_outside();
    test_misalign();
    test_reset_mid_busy();
    test_timeout();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter ACK_TIMEOUT, 15, max BUSY cycles awaiting dmem_ack before abort (range 2..15).
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low (asserted when 0).
REQ-004 MEM_InALUResult  input  32  byte address from EX/MEM stage register.
REQ-005 MEM_InRtData  input  32  store data from EX/MEM stage register.
REQ-006 MEM_InMemRead  input  1  load request.
REQ-007 MEM_InMemWrite  input  1  store request.
REQ-008 dmem_req  output  1  memory request, held until ack.
REQ-009 dmem_we  output  1  1 = write, 0 = read.
REQ-010 dmem_addr / dmem_wdata  output  32 each  address and write data to memory.
REQ-011 dmem_ack  input  1  one-cycle completion strobe from memory.
REQ-012 dmem_rdata  input  32  read data, valid with dmem_ack.
REQ-013 MEM_OutReadData  output  32  registered load result.
REQ-014 MEM_Stall  output  1  combinational; 1 holds EX/MEM (drives its write enable low) and upstream stages.
REQ-015 MEM_AlignErr / MEM_TimeoutErr  output  1 each  one-cycle error pulses.

Function
REQ-016 States: IDLE, BUSY, DONE.
REQ-017 Request = MEM_InMemRead | MEM_InMemWrite; aligned = MEM_InALUResult[1:0]==2'b00.
REQ-018 IDLE, aligned request: MEM_Stall=1, next BUSY, counter cleared.
REQ-019 IDLE, misaligned request: no dmem_req, MEM_Stall=0, MEM_AlignErr=1 next cycle, stay IDLE.
REQ-020 BUSY: dmem_req=1, MEM_Stall=1; dmem_addr=MEM_InALUResult, dmem_wdata=MEM_InRtData, dmem_we=MEM_InMemWrite (inputs stable because stalled).
REQ-021 Read and write both asserted: write performed, MEM_OutReadData unchanged.
REQ-022 BUSY with dmem_ack: on read, MEM_OutReadData<=dmem_rdata; next DONE.
REQ-023 BUSY without ack: counter increments; at counter==ACK_TIMEOUT-1 without ack, next DONE, MEM_TimeoutErr=1 next cycle, MEM_OutReadData<=0 on read.
REQ-024 DONE: MEM_Stall=0, dmem_req=0, inputs ignored; next IDLE unconditionally (prevents re-issue of the completing access).
REQ-025 Minimum latency: request in IDLE cycle 0, ack cycle 1, DONE cycle 2; MEM_Stall high exactly cycles 0-1.
REQ-026 Back-to-back memory ops: second access detected in IDLE the cycle after DONE.
REQ-027 dmem_ack outside BUSY ignored.

Reset
REQ-028 rst=0 forces state IDLE, counter 0, MEM_OutReadData=0, error pulses 0 immediately, without clock.
REQ-029 Reset mid-BUSY drops dmem_req same cycle; access abandoned, no result captured.

Structure
REQ-030 Package mem_ctrl_pkg holds state enum and ACK_TIMEOUT default.
REQ-031 Sub-module mem_timeout_cnt: 4-bit counter with clear, enable, terminal flag.

Verification
REQ-032 Load addr 0x100, ack cycle 1 with rdata 0xDEADBEEF -> stall 2 cycles, ReadData=0xDEADBEEF in DONE.
REQ-033 Store addr 0x204 data 0x12345678, ack after 4 BUSY cycles -> dmem_we=1, stall 5 cycles, ReadData unchanged.
REQ-034 Load addr 0x102 -> no dmem_req, stall 0, AlignErr one-cycle pulse.
REQ-035 Load, no ack -> TimeoutErr after 15 BUSY cycles, ReadData=0, state IDLE two cycles later.
REQ-036 rst=0 during BUSY cycle 2 -> dmem_req 0 immediately; after release, next load completes normally.
REQ-037 Two consecutive loads -> two distinct dmem_req episodes separated by DONE and IDLE.
